// File: rtl/cpu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// cpu_fetch_pkg -- shared CPU constants and types for the fetch stage.
//   RESET_VEC / IRQ_VEC / EXC_VEC : kernel-space vectors (bit 31 = kernel)
//   NOP                           : bubble instruction word
//   pcsrc_e                       : next-PC source encoding from control
//   ifid_t                        : IF/ID pipeline register contents
//   pc_incr()                     : PC+4 that never carries into bit 31
// ---------------------------------------------------------------------------
package cpu_fetch_pkg;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pcsrc_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ifid_t;

  // Bit 31 is the kernel-mode bit; sequential fetch must never flip it.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/cpu_fetch_if.sv
// ---------------------------------------------------------------------------
// cpu_fetch_if -- instruction memory bus between fetch and imem.
//   imem_addr  : fetch address (driven by fetch, master)
//   imem_rdata : instruction word, combinational read of imem_addr (slave)
// ---------------------------------------------------------------------------
interface cpu_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/cpu_fetch.sv
// ---------------------------------------------------------------------------
// cpu_fetch -- PC register, next-PC selection and IF/ID register.
//   clk, reset(active-low, synchronous), stall
//   imem         : instruction memory bus (cpu_fetch_if.master)
//   PCSrc, branch_taken, jr_target : redirect controls for the ID instruction
//   irq, Exception                 : interrupt request / undefined-instr flag
//   opcode, Funct, pchigh, Interrupt, id_instr, id_valid, id_pc,
//   id_pc_plus4, ret_addr          : ID-stage outputs to control/datapath
// Priority of next PC: stall > exception > interrupt > redirect > PC+4.
// Any taken redirect, exception or interrupt squashes the fetched word and
// puts a one-cycle bubble into IF/ID.
// ---------------------------------------------------------------------------
module cpu_fetch
  import cpu_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  cpu_fetch_if.master      imem,
  input  logic [1:0]       PCSrc,
  input  logic             branch_taken,
  input  logic [31:0]      jr_target,
  input  logic             irq,
  input  logic             Exception,
  output logic [5:0]       opcode,
  output logic [5:0]       Funct,
  output logic             pchigh,
  output logic             Interrupt,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc_plus4,
  output logic [31:0]      ret_addr
);

  logic [31:0] r_pc;
  ifid_t       r_ifid;
  logic        r_irq_pending;

  logic [31:0] w_incr;
  logic [30:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic        w_exc_acc;
  logic        w_intr;
  logic        w_redirect;
  logic [31:0] w_redir_tgt;
  logic [31:0] w_pc_nxt;
  ifid_t       w_ifid_nxt;
  logic        w_pend_nxt;

  assign w_incr   = pc_incr(r_pc);

  // Branch offset only touches bits 30:0 so a branch cannot leave kernel mode.
  assign w_br_off = {{13{r_ifid.instr[15]}}, r_ifid.instr[15:0], 2'b00};
  assign w_br_tgt = {r_ifid.pc[31], r_ifid.pc_plus4[30:0] + w_br_off};
  assign w_j_tgt  = {r_ifid.pc[31], r_ifid.pc_plus4[30:28],
                     r_ifid.instr[25:0], 2'b00};

  // Undefined instructions trap only from user mode; kernel ones are ignored.
  assign w_exc_acc = r_ifid.valid & Exception & ~r_ifid.pc[31] & ~stall;

  // Interrupts wait for a real user-mode instruction; its PC is the return
  // address, so a bubble or kernel code keeps the request pending.
  assign w_intr = r_irq_pending & r_ifid.valid & ~r_ifid.pc[31] & ~stall
                & ~w_exc_acc;

  always_comb begin
    w_redirect  = 1'b0;
    w_redir_tgt = w_incr;
    if (r_ifid.valid) begin
      case (pcsrc_e'(PCSrc))
        PCSRC_BR: begin
          w_redirect  = branch_taken;
          w_redir_tgt = w_br_tgt;
        end
        PCSRC_J: begin
          w_redirect  = 1'b1;
          w_redir_tgt = w_j_tgt;
        end
        PCSRC_JR: begin
          // Only path allowed to drop the kernel bit.
          w_redirect  = 1'b1;
          w_redir_tgt = jr_target;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_pc_nxt   = r_pc;
    w_ifid_nxt = r_ifid;
    if (!stall) begin
      w_ifid_nxt = '{instr: imem.imem_rdata, valid: 1'b1,
                     pc: r_pc, pc_plus4: w_incr};
      if (w_exc_acc)       w_pc_nxt = EXC_VEC;
      else if (w_intr)     w_pc_nxt = IRQ_VEC;
      else if (w_redirect) w_pc_nxt = w_redir_tgt;
      else                 w_pc_nxt = w_incr;
      if (w_exc_acc | w_intr | w_redirect) begin
        w_ifid_nxt.instr = NOP;
        w_ifid_nxt.valid = 1'b0;
      end
    end
  end

  // A new request arriving in the acceptance cycle is kept, not lost.
  assign w_pend_nxt = irq | (r_irq_pending & ~w_intr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc          <= RESET_VEC;
      r_ifid        <= '{instr: NOP, valid: 1'b0,
                         pc: RESET_VEC, pc_plus4: pc_incr(RESET_VEC)};
      r_irq_pending <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_ifid        <= w_ifid_nxt;
      r_irq_pending <= w_pend_nxt;
    end
  end

  assign imem.imem_addr = r_pc;
  assign id_instr       = r_ifid.instr;
  assign id_valid       = r_ifid.valid;
  assign id_pc          = r_ifid.pc;
  assign id_pc_plus4    = r_ifid.pc_plus4;
  assign opcode         = r_ifid.instr[31:26];
  assign Funct          = r_ifid.instr[5:0];
  assign pchigh         = r_ifid.pc[31];
  assign Interrupt      = w_intr;
  assign ret_addr       = w_intr ? r_ifid.pc : r_ifid.pc_plus4;

endmodule
